// File: rtl/inv_shift_rows_serial_if.sv
// Byte-stream handshake bundle for inv_shift_rows_serial.
//
// Signals:
//   in_valid  / in_ready  / in_byte         : input byte stream, byte k = 4*col + row
//   out_valid / out_ready / out_byte / out_last : result byte stream, same ordering
//   fwd_mode                                 : only with ISR_FWD_MODE_EN, 1 = forward ShiftRows
//
// Modports:
//   slave  : the shift-rows block
//   master : the environment driving the input stream and sinking the output stream
//
// Optional feature macro: ISR_FWD_MODE_EN
interface inv_shift_rows_serial_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
`ifdef ISR_FWD_MODE_EN
  logic       fwd_mode;
`endif

  modport slave (
    input  in_valid,
    input  in_byte,
    input  out_ready,
`ifdef ISR_FWD_MODE_EN
    input  fwd_mode,
`endif
    output in_ready,
    output out_valid,
    output out_byte,
    output out_last
  );

  modport master (
    output in_valid,
    output in_byte,
    output out_ready,
`ifdef ISR_FWD_MODE_EN
    output fwd_mode,
`endif
    input  in_ready,
    input  out_valid,
    input  out_byte,
    input  out_last
  );
endinterface

// File: rtl/inv_shift_rows_serial.sv
// Serial AES InvShiftRows: accepts a 16-byte state one byte per transfer and
// emits the row-rotated state one byte per transfer. Two 128-bit banks are
// ping-ponged so one block can be filled while the previous one drains.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : inv_shift_rows_serial_if.slave (input/output byte handshakes)
//
// Byte ordering: k = 4*col + row, byte 0 first, on both sides.
// Output byte j = 4c+r is taken from bank byte 4*((c-r) mod 4) + r.
//
// Optional feature macro: ISR_FWD_MODE_EN
//   Adds bus.fwd_mode, sampled on the first byte of each block and kept per
//   bank; when set the block uses the forward mapping 4*((c+r) mod 4) + r.
module inv_shift_rows_serial (
  input  logic                   clk,
  input  logic                   rst,
  inv_shift_rows_serial_if.slave bus
);

  // Bank storage carries no reset; only the control state does.
  logic [127:0] bank_q [2];
  logic [127:0] bank_d [2];

  logic [1:0] full_q, full_d;
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [3:0] rcnt_q, rcnt_d;

  logic       in_ready;
  logic       out_valid;
  logic       in_fire;
  logic       out_fire;
  logic       rd_fwd;
  logic [1:0] src_col;
  logic [3:0] src_idx;
  logic [7:0] rd_byte;

  // Handshake state comes only from registered flags, so in_ready never
  // depends on out_ready and a bank freed this cycle is reusable next cycle.
  always_comb begin
    in_ready  = ~full_q[wptr_q];
    out_valid = full_q[rptr_q];
    in_fire   = bus.in_valid & in_ready;
    out_fire  = out_valid & bus.out_ready;
  end

`ifdef ISR_FWD_MODE_EN
  logic [1:0] mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (in_fire && (wcnt_q == 4'd0)) begin
      mode_d[wptr_q] = bus.fwd_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 2'b00;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb rd_fwd = mode_q[rptr_q];
`else
  always_comb rd_fwd = 1'b0;
`endif

  // Column arithmetic is 2 bits wide so the mod-4 wrap is free.
  always_comb begin
    if (rd_fwd) begin
      src_col = rcnt_q[3:2] + rcnt_q[1:0];
    end else begin
      src_col = rcnt_q[3:2] - rcnt_q[1:0];
    end
    src_idx = {src_col, rcnt_q[1:0]};
    rd_byte = bank_q[rptr_q][{src_idx, 3'b000} +: 8];
  end

  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    if (in_fire) begin
      bank_d[wptr_q][{wcnt_q, 3'b000} +: 8] = bus.in_byte;
    end
  end

  // The write bank is never the bank being completed on the read side in the
  // same cycle (one is empty, the other full), so set and clear never collide.
  always_comb begin
    full_d = full_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;

    if (in_fire) begin
      if (wcnt_q == 4'hF) begin
        full_d[wptr_q] = 1'b1;
        wptr_d         = ~wptr_q;
        wcnt_d         = 4'd0;
      end else begin
        wcnt_d = wcnt_q + 4'd1;
      end
    end

    if (out_fire) begin
      if (rcnt_q == 4'hF) begin
        full_d[rptr_q] = 1'b0;
        rptr_d         = ~rptr_q;
        rcnt_d         = 4'd0;
      end else begin
        rcnt_d = rcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 2'b00;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      wcnt_q <= 4'd0;
      rcnt_q <= 4'd0;
    end else begin
      full_q <= full_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  // Outputs are a function of registered state only, so they stay put while
  // the consumer stalls.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_byte  = out_valid ? rd_byte : 8'h00;
    bus.out_last  = out_valid & (rcnt_q == 4'hF);
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Directed and randomised bench for inv_shift_rows_serial.
module tb_inv_shift_rows_serial;

  logic clk;
  logic rst;

  inv_shift_rows_serial_if bus ();

  inv_shift_rows_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int cyc;
  int stab_err;
  int stall_cnt;
  int first_out_cyc;
  int last_out_cyc;
  int last_in_cyc;

  bit         in_fire;
  bit         out_fire;
  bit         hold_prev;
  logic [7:0] prev_byte;
  logic       prev_last;

  logic [7:0] in_q   [$];
  logic [7:0] out_q  [$];
  logic [7:0] stim_q [$];
  logic       last_q [$];

  logic [7:0] exp_inv [16];
  logic [7:0] exp_fwd [16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Source byte for result byte j, straight from the row-rotation definition.
  function automatic int src_of(input int j, input bit fwd);
    int c;
    int r;
    c = j / 4;
    r = j % 4;
    if (fwd) return 4 * ((c + r) % 4) + r;
    return 4 * ((c - r + 4) % 4) + r;
  endfunction

  // One clock: drive at the falling edge, observe 1 ns later, edge follows.
  task automatic drive_cycle(input logic iv, input logic [7:0] ib, input logic ordy);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_byte   = ib;
    bus.out_ready = ordy;
    #1;
    in_fire  = iv && bus.in_ready;
    out_fire = bus.out_valid && ordy;
    if (iv && !bus.in_ready) stall_cnt++;
    if (hold_prev && bus.out_valid) begin
      if (bus.out_byte !== prev_byte || bus.out_last !== prev_last) stab_err++;
    end
    hold_prev = bus.out_valid && !ordy;
    prev_byte = bus.out_byte;
    prev_last = bus.out_last;
    if (in_fire) in_q.push_back(ib);
    if (out_fire) begin
      out_q.push_back(bus.out_byte);
      last_q.push_back(bus.out_last);
    end
    cyc++;
  endtask

  task automatic clear_logs();
    in_q.delete();
    out_q.delete();
    last_q.delete();
    hold_prev = 1'b0;
    stall_cnt = 0;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  // Push stim_q in order and collect n_out results, bounded by a cycle budget.
  task automatic stream(input int n_out, input bit rnd);
    int         sent;
    int         budget;
    logic       iv;
    logic       ordy;
    logic [7:0] ib;
    sent          = 0;
    budget        = 0;
    first_out_cyc = -1;
    while (out_q.size() < n_out && budget < 20000) begin
      iv   = (sent < stim_q.size()) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      ib   = iv ? stim_q[sent] : 8'($urandom_range(0, 255));
      ordy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      drive_cycle(iv, ib, ordy);
      if (in_fire) begin
        sent++;
        last_in_cyc = cyc;
      end
      if (out_fire) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      budget++;
    end
    check_eq("stream_out_count", 32'(out_q.size()), 32'(n_out));
  endtask

  task automatic check_model(input bit fwd);
    for (int k = 0; k < out_q.size(); k++) begin
      int b;
      int j;
      b = k / 16;
      j = k % 16;
      check_eq($sformatf("perm[%0d]", k), 32'(out_q[k]), 32'(in_q[16 * b + src_of(j, fwd)]));
      check_eq($sformatf("last[%0d]", k), 32'(last_q[k]), 32'(j == 15));
    end
  endtask

  task automatic check_table(input string tag, input logic [7:0] tbl [16]);
    for (int k = 0; k < 16; k++) begin
      check_eq($sformatf("%s_byte[%0d]", tag, k), 32'(out_q[k]), 32'(tbl[k]));
      check_eq($sformatf("%s_last[%0d]", tag, k), 32'(last_q[k]), 32'(k == 15));
    end
  endtask

  task automatic load_ramp();
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(8'(i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cyc       = 0;
    stab_err  = 0;
    stall_cnt = 0;
    hold_prev = 1'b0;
    prev_byte = 8'h00;
    prev_last = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;
`ifdef ISR_FWD_MODE_EN
    bus.fwd_mode  = 1'b0;
`endif
    exp_inv = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    exp_fwd = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};

    // Reset state
    assert_reset();
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
    check_eq("rst_out_byte", 32'(bus.out_byte), 32'd0);
    release_reset();

    // Ramp 00..0F, consumer always ready
    load_ramp();
    stream(16, 1'b0);
    check_table("ramp", exp_inv);
    check_eq("ramp_latency", 32'(first_out_cyc - last_in_cyc), 32'd1);

    // Three back-to-back blocks, both sides always ready
    assert_reset();
    release_reset();
    stim_q.delete();
    for (int i = 0; i < 48; i++) stim_q.push_back(8'(i * 7 + 3));
    stream(48, 1'b0);
    check_eq("b2b_in_count", 32'(in_q.size()), 32'd48);
    check_eq("b2b_out_span", 32'(last_out_cyc - first_out_cyc), 32'd47);
    check_eq("b2b_in_stalls", 32'(stall_cnt), 32'd0);
    check_model(1'b0);

    // Consumer stalled: 40 offered, 32 fit
    assert_reset();
    release_reset();
    stab_err = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b0);
      if (i == 15) check_eq("stall_valid_15", 32'(bus.out_valid), 32'd0);
      if (i == 16) begin
        check_eq("stall_valid_16", 32'(bus.out_valid), 32'd1);
        check_eq("stall_byte_16", 32'(bus.out_byte), 32'd0);
      end
      if (i == 31) check_eq("stall_ready_31", 32'(bus.in_ready), 32'd1);
      if (i == 32) check_eq("stall_ready_32", 32'(bus.in_ready), 32'd0);
    end
    check_eq("stall_accepted", 32'(in_q.size()), 32'd32);
    check_eq("stall_ready_end", 32'(bus.in_ready), 32'd0);
    check_eq("stall_byte_end", 32'(bus.out_byte), 32'd0);
    check_eq("stall_last_end", 32'(bus.out_last), 32'd0);
    check_eq("stall_stable", 32'(stab_err), 32'd0);
    stim_q.delete();
    stream(32, 1'b0);
    check_model(1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    check_eq("drain_ready", 32'(bus.in_ready), 32'd1);
    check_eq("drain_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a block
    assert_reset();
    release_reset();
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, 8'(8'hA0 + i), 1'b1);
    assert_reset();
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    release_reset();
    load_ramp();
    stream(16, 1'b0);
    check_table("midrst", exp_inv);
    check_eq("midrst_latency", 32'(first_out_cyc - last_in_cyc), 32'd1);

`ifdef ISR_FWD_MODE_EN
    // Forward mode, then undo it with the inverse mapping
    assert_reset();
    release_reset();
    load_ramp();
    bus.fwd_mode = 1'b1;
    stream(16, 1'b0);
    check_table("fwd", exp_fwd);
    bus.fwd_mode = 1'b0;
    stim_q.delete();
    for (int k = 0; k < 16; k++) stim_q.push_back(out_q[k]);
    clear_logs();
    stream(16, 1'b0);
    for (int k = 0; k < 16; k++) check_eq($sformatf("fwd_undo[%0d]", k), 32'(out_q[k]), 32'(k));
`endif

    // 100 random blocks with random handshakes
    assert_reset();
    release_reset();
    stim_q.delete();
    for (int i = 0; i < 1600; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    stream(1600, 1'b1);
    check_eq("rand_in_count", 32'(in_q.size()), 32'd1600);
    check_model(1'b0);
    check_eq("rand_stable", 32'(stab_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
